// File: rtl/rotate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rotate_arbiter
// Description : Two-requester round-robin front end for a shared 32-bit rotator
//               with a one-entry registered, source-tagged result stage.
// Revision    : 1.0
// ============================================================================
module rotate_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [4:0]       req0_amt,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [4:0]       req1_amt,
  input  logic             req1_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             src_q, src_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic             can_accept;
  logic             grant0, grant1;
  logic             push, pop;
  logic [WIDTH-1:0] sel_data;
  logic [4:0]       sel_amt;
  logic             sel_dir;
  logic [WIDTH-1:0] rot_result;

  // The complement amount is 6 bits wide so a=0 yields a shift of 32 (i.e. 0)
  // rather than aliasing back to 0 and OR-ing the operand onto itself.
  function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] d,
                                              input logic [4:0]       a,
                                              input logic             left);
    logic [5:0] inv;
    inv = 6'd32 - {1'b0, a};
    if (left) rotate = (d << a) | (d >> inv);
    else      rotate = (d >> a) | (d << inv);
  endfunction

  assign can_accept = (state_q == S_EMPTY) | out_ready;

  // Round-robin: on contention the requester that did not win last goes next.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready = grant0 & can_accept;
  assign req1_ready = grant1 & can_accept;

  assign push = req0_ready | req1_ready;
  assign pop  = (state_q == S_FULL) & out_ready;

  assign sel_data   = req1_ready ? req1_data : req0_data;
  assign sel_amt    = req1_ready ? req1_amt  : req0_amt;
  assign sel_dir    = req1_ready ? req1_dir  : req0_dir;
  assign rot_result = rotate(sel_data, sel_amt, sel_dir);

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    ops_d        = ops_q;

    if (pop) begin
      ops_d = ops_q + C_CNT_ONE;
    end

    case (state_q)
      S_EMPTY: begin
        if (push) state_d = S_FULL;
      end
      S_FULL: begin
        if (pop && !push) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase

    if (push) begin
      data_d       = rot_result;
      src_d        = req1_ready;
      last_grant_d = req1_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      data_q       <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
      ops_q        <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      ops_q        <= ops_d;
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign ops_done  = ops_q;

endmodule
`default_nettype wire

// File: tb/tb_rotate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotate_arbiter
// Description : Directed self-checking bench for rotate_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_rotate_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_dir;
  logic [31:0] req0_data;
  logic [4:0]  req0_amt;
  logic        req1_valid, req1_ready, req1_dir;
  logic [31:0] req1_data;
  logic [4:0]  req1_amt;
  logic        out_valid, out_ready, out_src;
  logic [31:0] out_data;
  logic [15:0] ops_done;

  // Second instance for counter wrap with a narrow counter
  logic        w_valid, w_ready0, w_ready1, w_out_valid, w_out_src;
  logic [31:0] w_out_data;
  logic [3:0]  w_ops;

  int tests = 0;
  int fails = 0;

  rotate_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .ops_done(ops_done)
  );

  rotate_arbiter #(.WIDTH(32), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst),
    .req0_valid(w_valid), .req0_ready(w_ready0), .req0_data(32'h0000_00A5),
    .req0_amt(5'd3), .req0_dir(1'b1),
    .req1_valid(1'b0), .req1_ready(w_ready1), .req1_data(32'h0),
    .req1_amt(5'd0), .req1_dir(1'b0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data),
    .out_src(w_out_src), .ops_done(w_ops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-shot op on a single requester; result checked after the accepting edge.
  task automatic issue(input bit which, input logic [31:0] d, input logic [4:0] a,
                       input logic dir, input logic [31:0] exp, input string tag);
    if (which) begin
      req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_dir = dir;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_dir = dir;
    end
    #1;
    chk({tag, "_rdy"}, {30'd0, req1_ready, req0_ready}, which ? 32'd2 : 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_src"}, {31'd0, out_src}, {31'd0, which});
  endtask

  logic [31:0] held;
  logic [15:0] ops_base;
  int          k0, k1;

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_data = '0; req0_amt = '0; req0_dir = 0;
    req1_valid = 0; req1_data = '0; req1_amt = '0; req1_dir = 0;
    out_ready = 1'b1; w_valid = 1'b0;
    step(); step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_src", {31'd0, out_src}, 32'd0);
    chk("rst_ops", {16'd0, ops_done}, 32'd0);
    rst = 1'b0;

    // Single-requester rotations, including amt=0 and amt=31 boundaries
    issue(1'b0, 32'h8000_0001, 5'd1, 1'b1, 32'h0000_0003, "rotl1");
    chk("ops_before_consume", {16'd0, ops_done}, 32'd0);
    step();
    chk("ops_after_consume", {16'd0, ops_done}, 32'd1);
    chk("pop_empty", {31'd0, out_valid}, 32'd0);
    chk("pop_hold_data", out_data, 32'h0000_0003);
    issue(1'b1, 32'h1234_5678, 5'd4, 1'b0, 32'h8123_4567, "rotr4");
    issue(1'b1, 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678, "rotr0");
    issue(1'b0, 32'h1234_5678, 5'd0, 1'b1, 32'h1234_5678, "rotl0");
    issue(1'b0, 32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000, "rotl31");
    issue(1'b1, 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, "rotr31");
    step();
    chk("ops_after_six", {16'd0, ops_done}, 32'd6);

    // Continuous contention: strict alternation starting at req0
    ops_base = ops_done;
    k0 = 0; k1 = 0;
    req0_valid = 1; req0_amt = 5'd4; req0_dir = 1'b1;
    req1_valid = 1; req1_amt = 5'd8; req1_dir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req0_data = 32'(k0 + 1);
      req1_data = 32'h100 + 32'(k1);
      #1;
      chk("rr_ready", {30'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      step();
      chk("rr_src", {31'd0, out_src}, 32'(i % 2));
      if (i % 2 == 0) begin
        chk("rr_data0", out_data, 32'(k0 + 1) << 4);
        k0++;
      end else begin
        chk("rr_data1", out_data, {8'(k1), 24'h000001});
        k1++;
      end
    end
    req0_valid = 0; req1_valid = 0;
    step();
    chk("rr_ops8", 32'(ops_done - ops_base), 32'd8);

    // Backpressure: result held, both requesters waiting
    out_ready = 1'b0;
    req0_valid = 1; req0_data = 32'h0000_00F0; req0_amt = 5'd4; req0_dir = 1'b0;
    req1_valid = 1; req1_data = 32'h0000_0F00; req1_amt = 5'd4; req1_dir = 1'b1;
    step();
    chk("bp_first_src", {31'd0, out_src}, 32'd0);
    chk("bp_first_data", out_data, 32'h0000_000F);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_low", {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
      chk("bp_data_stable", out_data, held);
    end
    ops_base = ops_done;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
    step();
    chk("bp_no_bubble_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_no_bubble_src", {31'd0, out_src}, 32'd1);
    chk("bp_no_bubble_data", out_data, 32'h0000_F000);
    chk("bp_consumed", 32'(ops_done - ops_base), 32'd1);

    // Make req0 the last grant, then reset with its result held
    step();
    chk("pre_rst_src", {31'd0, out_src}, 32'd0);
    out_ready = 1'b0; req0_valid = 0; req1_valid = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ops", {16'd0, ops_done}, 32'd0);
    out_ready = 1'b1; req0_valid = 1; req1_valid = 1;
    #1;
    chk("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 0; req1_valid = 0;

    // Narrow counter wrap: 17 consumed results
    w_valid = 1'b1;
    for (int i = 0; i < 17; i++) step();
    w_valid = 1'b0;
    step();
    chk("wrap_ops", {28'd0, w_ops}, 32'd1);
    chk("wrap_data", w_out_data, 32'h0000_0528);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
